// File: rtl/shifter_pkg.sv
// Shared definitions for the single-step shifter: direction encodings and the
// width-generic one-position shift helper.
package shifter_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Widest operand the helper handles; shifter_core zero-extends into this.
    localparam int SHIFT_MAX_W = 64;
    localparam int SHIFT_IDX_W = $clog2(SHIFT_MAX_W);

    // Shift v by one position. msb is the index of the top bit of the real
    // operand, so a right shift can place the fill bit there.
    function automatic logic [SHIFT_MAX_W-1:0] shift_step(
        input logic [SHIFT_MAX_W-1:0] v,
        input logic [SHIFT_IDX_W-1:0] msb,
        input logic                   dir,
        input logic                   fill
    );
        logic [SHIFT_MAX_W-1:0] r;
        if (dir == DIR_LEFT) begin
            r = {v[SHIFT_MAX_W-2:0], fill};
        end else begin
            r      = v >> 1;
            r[msb] = fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_core.sv
// Combinational next-value logic of the shifter. Defining SHIFTER_ROTATE_EN
// turns the logical shift into a rotate (fill bit = bit shifted out).
module shifter_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] operand_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] result_o
);

    logic fill;

`ifdef SHIFTER_ROTATE_EN
    assign fill = (dir_i == DIR_RIGHT) ? operand_i[0] : operand_i[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    // Upper bits of the wide helper result are never meaningful; the cast drops them.
    assign result_o = WIDTH'(shift_step(SHIFT_MAX_W'(operand_i),
                                        SHIFT_IDX_W'(WIDTH - 1),
                                        dir_i, fill));

endmodule

// File: rtl/shifter.sv
// Single-step shifter with registered output and asynchronous active-low reset.
// Build option SHIFTER_ROTATE_EN selects rotate instead of logical shift.
module shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             dir,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    shifter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .operand_i (a),
        .dir_i     (dir),
        .result_o  (y_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_shifter.sv
// Directed bench for shifter at WIDTH=4; expected values follow the
// SHIFTER_ROTATE_EN build option.
module tb_shifter;

    localparam int W = 4;

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clk_run = 1'b0;
    logic         rst;
    logic         dir;
    logic [W-1:0] a;
    logic [W-1:0] y;

    int total = 0;
    int bad   = 0;

    shifter #(
        .WIDTH (W)
    ) dut (
        .dir (dir),
        .clk (clk),
        .rst (rst),
        .a   (a),
        .y   (y)
    );

    // Gated clock so reset behaviour can be checked with no edges at all.
    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // dir must be known whenever the design is out of reset.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            total++;
            assert (!$isunknown(dir)) else begin
                bad++;
                $error("FAIL dir_known observed=%b expected=0/1", dir);
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dir = 1'b0;
        a   = 4'b0000;

        // Reset with the clock stopped clears y immediately.
        #2 rst = 1'b0;
        #1 check("reset_async", y, 4'b0000);

        a = 4'b1111;
        clk_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_then_settle();
            check("reset_hold", y, 4'b0000);
        end

        // Release and left shift.
        rst = 1'b1; dir = 1'b0; a = 4'b0101;
        edge_then_settle();
        check("left_0101", y, 4'b1010);
        for (int i = 0; i < 2; i++) begin
            edge_then_settle();
            check("left_hold", y, 4'b1010);
        end

        dir = 1'b1;
        edge_then_settle();
        check("right_0101", y, ROT ? 4'b1010 : 4'b0010);

        dir = 1'b0;
        edge_then_settle();
        check("dir_switch", y, 4'b1010);

        // Boundary bits leaving the word.
        a = 4'b1001; dir = 1'b0;
        edge_then_settle();
        check("left_1001", y, ROT ? 4'b0011 : 4'b0010);
        dir = 1'b1;
        edge_then_settle();
        check("right_1001", y, ROT ? 4'b1100 : 4'b0100);

        a = 4'b1111; dir = 1'b0;
        edge_then_settle();
        check("left_1111", y, ROT ? 4'b1111 : 4'b1110);
        dir = 1'b1;
        edge_then_settle();
        check("right_1111", y, ROT ? 4'b1111 : 4'b0111);

        a = 4'b0000;
        edge_then_settle();
        check("right_0000", y, 4'b0000);

        a = 4'b1000; dir = 1'b0;
        edge_then_settle();
        check("left_1000", y, ROT ? 4'b0001 : 4'b0000);

        // Reset mid-operation, cleared without an edge.
        a = 4'b0101; dir = 1'b0;
        edge_then_settle();
        check("pre_reset", y, 4'b1010);
        #2 rst = 1'b0;
        #1 check("reset_mid", y, 4'b0000);
        dir = 1'b1; a = 4'b0110;
        #1 rst = 1'b1;
        #1 check("reset_released_no_edge", y, 4'b0000);
        edge_then_settle();
        check("post_release", y, 4'b0011);

        // Glitches between edges are invisible.
        a = 4'b0011; dir = 1'b0;
        #2 a = 4'b1100; dir = 1'b1;
        #2 a = 4'b0011; dir = 1'b0;
        edge_then_settle();
        check("glitch_restore", y, 4'b0110);

        #1 dir = 1'b1;
        #2 a = 4'b1110;
        #2 dir = 1'b0; a = 4'b0011;
        edge_then_settle();
        check("glitch_restore2", y, 4'b0110);

        clk_run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
